// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset PC and entry layout for the fetch queue slice.
package fetch_queue_pkg;

    localparam int unsigned     XLEN             = 64;
    localparam int unsigned     INSN_WIDTH       = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INSN_WIDTH-1:0] insn;
    } fq_entry_t;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_DROP,
        RSP_KEEP
    } rsp_action_e;

endpackage

// File: rtl/fq_fifo.sv
// Circular FIFO storage for the fetch queue; push and pop may coincide at any
// occupancy, flush empties it in one cycle.
module fq_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned    PW      = $clog2(DEPTH);
    localparam int unsigned    CW      = PW + 1;
    localparam logic [PW-1:0]  PTR_ONE = 1;
    localparam logic [CW-1:0]  CNT_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop frees the slot the same cycle, so a push into a full FIFO is legal then.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tags in-order responses
// with their PC and drops stale ones after a redirect. Optional same-cycle
// response forwarding when empty is enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  imem_req,
    output logic [XLEN-1:0]       imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rsp_valid,
    input  logic [INSN_WIDTH-1:0] imem_rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_pc_plus_4,
    output logic [INSN_WIDTH-1:0] out_instruction
);

    localparam int unsigned    CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  CNT_ONE = 1;
    localparam int unsigned    EW      = $bits(fq_entry_t);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_occ;
    logic [CW:0]     w_budget;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [EW-1:0]   w_fifo_rdata;
    logic            w_accept;
    logic            w_rsp_counted;
    logic [CW-1:0]   w_out_after_rsp;
    rsp_action_e     w_action;
    logic            w_keep;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    fq_entry_t       w_rsp_entry;
    fq_entry_t       w_head;

    assign w_budget  = {1'b0, w_occ} + {1'b0, r_outstanding};
    assign imem_req  = !sys_rst && !redirect_valid && (w_budget < (CW+1)'(DEPTH));
    assign imem_addr = r_fetch_pc;
    assign w_accept  = imem_req && imem_gnt;

    assign w_rsp_counted   = imem_rsp_valid && (r_outstanding != '0);
    assign w_out_after_rsp = w_rsp_counted ? r_outstanding - CNT_ONE : r_outstanding;

    always_comb begin
        w_action = RSP_NONE;
        if (w_rsp_counted) begin
            if (redirect_valid || (r_drop_cnt != '0)) w_action = RSP_DROP;
            else                                      w_action = RSP_KEEP;
        end
    end

    assign w_keep      = (w_action == RSP_KEEP);
    assign w_rsp_entry = '{pc: r_resp_pc, insn: imem_rsp_data};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_keep && w_fifo_empty;
    assign w_head   = w_bypass ? w_rsp_entry : (w_fifo_empty ? '0 : fq_entry_t'(w_fifo_rdata));
`else
    assign w_bypass = 1'b0;
    assign w_head   = w_fifo_empty ? '0 : fq_entry_t'(w_fifo_rdata);
`endif

    assign out_valid       = !w_fifo_empty || w_bypass;
    assign out_pc          = w_head.pc;
    assign out_instruction = w_head.insn;
    assign out_pc_plus_4   = out_valid ? w_head.pc + 64'd4 : '0;

    // A forwarded response consumed in the same cycle never occupies a slot.
    assign w_pop  = !w_fifo_empty && out_ready && !redirect_valid;
    assign w_push = w_keep && !(w_bypass && out_ready);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= redirect_pc;
            r_resp_pc     <= redirect_pc;
            r_outstanding <= w_out_after_rsp;
            r_drop_cnt    <= w_out_after_rsp;
        end else begin
            if (w_accept)               r_fetch_pc <= r_fetch_pc + 64'd4;
            if (w_keep)                 r_resp_pc  <= r_resp_pc + 64'd4;
            if (w_action == RSP_DROP)   r_drop_cnt <= r_drop_cnt - CNT_ONE;
            r_outstanding <= w_accept ? w_out_after_rsp + CNT_ONE : w_out_after_rsp;
        end
    end

    fq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_rsp_entry),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_occ)
    );

    // Credit accounting keeps occupancy + outstanding <= DEPTH, so a kept
    // response never meets a full FIFO without a simultaneous pop.
    logic w_unused_full;
    assign w_unused_full = w_fifo_full;

endmodule
